// File: rtl/hn_pkg.sv
// Shared definitions for the home-node entry tracker: CHI request opcodes
// and the single-entry FSM state encoding.
package hn_pkg;

    typedef enum logic [1:0] {
        OP_READ_UNIQUE    = 2'd0,
        OP_MAKE_UNIQUE    = 2'd1,
        OP_WRITE_BACK     = 2'd2,
        OP_RESERVED       = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SNP_SEND = 3'd1,
        ST_SNP_WAIT = 3'd2,
        ST_MRD_REQ  = 3'd3,
        ST_MRD_WAIT = 3'd4,
        ST_RSP_SEND = 3'd5,
        ST_ACK_WAIT = 3'd6,
        ST_MWR_REQ  = 3'd7
    } state_e;

endpackage

// File: rtl/hn_entry_state.sv
// Single-entry home-node transaction tracker. Accepts one CHI request at a
// time, optionally snoops a peer, reads/writes memory as the opcode needs,
// sends the completion and waits for the requester's final acknowledgement.
// All valid outputs are decoded from registered state only.
module hn_entry_state
    import hn_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rxreq_valid,
    output logic             rxreq_ready,
    input  logic [1:0]       rxreq_op,
    input  logic             rxreq_snp_needed,
    output logic             txsnp_valid,
    input  logic             txsnp_ready,
    input  logic             rxrsp_snpresp_valid,
    input  logic             rxdat_snprespdata_valid,
    output logic             mem_rd_valid,
    input  logic             mem_rd_ready,
    input  logic             mem_rd_done,
    output logic             mem_wr_valid,
    input  logic             mem_wr_ready,
    output logic             txrsp_comp_valid,
    output logic             txrsp_compdbidresp_valid,
    input  logic             txrsp_ready,
    output logic             txdat_compdata_valid,
    input  logic             txdat_ready,
    input  logic             rxrsp_compack_valid,
    input  logic             rxdat_cbwrdata_valid,
    output logic             busy,
    output logic             proto_err,
    output logic [CNT_W-1:0] done_cnt
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic               snp_q, snp_d;
    logic               dfs_q, dfs_d;   // completion data came from the snooped peer
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rsp_ready;
    logic               snp_pulse;
    logic               ack_pulse;

    // Next-state, latched request fields, sticky error and completion counter
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        snp_d     = snp_q;
        dfs_d     = dfs_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        snp_pulse = rxrsp_snpresp_valid | rxdat_snprespdata_valid;
        ack_pulse = rxrsp_compack_valid | rxdat_cbwrdata_valid;
        // CompData travels on the DAT channel, Comp/CompDBIDResp on RSP
        rsp_ready = (op_q == OP_READ_UNIQUE) ? txdat_ready : txrsp_ready;

        case (state_q)
            ST_IDLE: begin
                if (rxreq_valid) begin
                    op_d  = op_e'(rxreq_op);
                    snp_d = rxreq_snp_needed;
                    dfs_d = 1'b0;
                    case (op_e'(rxreq_op))
                        OP_READ_UNIQUE: state_d = rxreq_snp_needed ? ST_SNP_SEND : ST_MRD_REQ;
                        OP_MAKE_UNIQUE: state_d = rxreq_snp_needed ? ST_SNP_SEND : ST_RSP_SEND;
                        OP_WRITE_BACK:  state_d = ST_RSP_SEND;
                        default:        err_d   = 1'b1;
                    endcase
                end
            end
            ST_SNP_SEND: if (txsnp_ready) state_d = ST_SNP_WAIT;
            ST_SNP_WAIT: begin
                // Data-carrying snoop response takes priority over dataless one
                if (rxdat_snprespdata_valid) begin
                    state_d = ST_RSP_SEND;
                    dfs_d   = 1'b1;
                end else if (rxrsp_snpresp_valid) begin
                    state_d = (op_q == OP_READ_UNIQUE) ? ST_MRD_REQ : ST_RSP_SEND;
                end
            end
            ST_MRD_REQ:  if (mem_rd_ready) state_d = ST_MRD_WAIT;
            ST_MRD_WAIT: if (mem_rd_done)  state_d = ST_RSP_SEND;
            ST_RSP_SEND: if (rsp_ready)    state_d = ST_ACK_WAIT;
            ST_ACK_WAIT: begin
                if (op_q == OP_WRITE_BACK) begin
                    if (rxdat_cbwrdata_valid) state_d = ST_MWR_REQ;
                end else if (rxrsp_compack_valid) begin
                    // Dirty data pulled from the peer must be written back
                    state_d = (op_q == OP_READ_UNIQUE && snp_q && dfs_q) ? ST_MWR_REQ : ST_IDLE;
                end
            end
            ST_MWR_REQ:  if (mem_wr_ready) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        // Pulses arriving in the wrong state are flagged and otherwise ignored
        if (snp_pulse && state_q != ST_SNP_WAIT)   err_d = 1'b1;
        if (mem_rd_done && state_q != ST_MRD_WAIT) err_d = 1'b1;
        if (ack_pulse && state_q != ST_ACK_WAIT)   err_d = 1'b1;
        if (state_q == ST_ACK_WAIT &&
            ((op_q == OP_WRITE_BACK && rxrsp_compack_valid) ||
             (op_q != OP_WRITE_BACK && rxdat_cbwrdata_valid)))
            err_d = 1'b1;

        if (state_q != ST_IDLE && state_d == ST_IDLE)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // State and control registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ_UNIQUE;
            snp_q   <= 1'b0;
            dfs_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            snp_q   <= snp_d;
            dfs_q   <= dfs_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake and status outputs decoded from registered state
    always_comb begin
        rxreq_ready              = (state_q == ST_IDLE);
        busy                     = (state_q != ST_IDLE);
        txsnp_valid              = (state_q == ST_SNP_SEND);
        mem_rd_valid             = (state_q == ST_MRD_REQ);
        mem_wr_valid             = (state_q == ST_MWR_REQ);
        txdat_compdata_valid     = (state_q == ST_RSP_SEND) && (op_q == OP_READ_UNIQUE);
        txrsp_comp_valid         = (state_q == ST_RSP_SEND) && (op_q == OP_MAKE_UNIQUE);
        txrsp_compdbidresp_valid = (state_q == ST_RSP_SEND) && (op_q == OP_WRITE_BACK);
        proto_err                = err_q;
        done_cnt                 = cnt_q;
    end

endmodule

// File: tb/tb_hn_entry_state.sv
// Directed bench for hn_entry_state: each scenario is stepped cycle by cycle
// against hand-computed expected outputs.
module tb_hn_entry_state;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rxreq_valid, rxreq_ready;
    logic [1:0] rxreq_op;
    logic       rxreq_snp_needed;
    logic       txsnp_valid, txsnp_ready;
    logic       rxrsp_snpresp_valid, rxdat_snprespdata_valid;
    logic       mem_rd_valid, mem_rd_ready, mem_rd_done;
    logic       mem_wr_valid, mem_wr_ready;
    logic       txrsp_comp_valid, txrsp_compdbidresp_valid, txrsp_ready;
    logic       txdat_compdata_valid, txdat_ready;
    logic       rxrsp_compack_valid, rxdat_cbwrdata_valid;
    logic       busy, proto_err;
    logic [7:0] done_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hn_entry_state #(.CNT_W(8)) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .rxreq_valid              (rxreq_valid),
        .rxreq_ready              (rxreq_ready),
        .rxreq_op                 (rxreq_op),
        .rxreq_snp_needed         (rxreq_snp_needed),
        .txsnp_valid              (txsnp_valid),
        .txsnp_ready              (txsnp_ready),
        .rxrsp_snpresp_valid      (rxrsp_snpresp_valid),
        .rxdat_snprespdata_valid  (rxdat_snprespdata_valid),
        .mem_rd_valid             (mem_rd_valid),
        .mem_rd_ready             (mem_rd_ready),
        .mem_rd_done              (mem_rd_done),
        .mem_wr_valid             (mem_wr_valid),
        .mem_wr_ready             (mem_wr_ready),
        .txrsp_comp_valid         (txrsp_comp_valid),
        .txrsp_compdbidresp_valid (txrsp_compdbidresp_valid),
        .txrsp_ready              (txrsp_ready),
        .txdat_compdata_valid     (txdat_compdata_valid),
        .txdat_ready              (txdat_ready),
        .rxrsp_compack_valid      (rxrsp_compack_valid),
        .rxdat_cbwrdata_valid     (rxdat_cbwrdata_valid),
        .busy                     (busy),
        .proto_err                (proto_err),
        .done_cnt                 (done_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All seven outputs that carry valids/ready/busy packed for one-shot checks
    function automatic logic [31:0] outs();
        return {25'd0, rxreq_ready, busy, txsnp_valid, mem_rd_valid, mem_wr_valid,
                txrsp_comp_valid | txrsp_compdbidresp_valid, txdat_compdata_valid};
    endfunction

    task automatic request(input logic [1:0] op, input logic snp);
        rxreq_valid = 1'b1; rxreq_op = op; rxreq_snp_needed = snp;
        step();
        rxreq_valid = 1'b0; rxreq_op = 2'd0; rxreq_snp_needed = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        rxreq_valid = 0; rxreq_op = 0; rxreq_snp_needed = 0;
        txsnp_ready = 1; mem_rd_ready = 1; mem_wr_ready = 1; txrsp_ready = 1; txdat_ready = 1;
        rxrsp_snpresp_valid = 0; rxdat_snprespdata_valid = 0; mem_rd_done = 0;
        rxrsp_compack_valid = 0; rxdat_cbwrdata_valid = 0;
        #23 reset_n = 1'b1;
        step();

        // Reset state: only rxreq_ready high
        check_val("rst_outs", outs(), 32'h40);
        check_val("rst_err", proto_err, 0);
        check_val("rst_cnt", done_cnt, 0);

        // ReadUnique, no snoop, all readies high
        request(2'd0, 1'b0);                        // now N+1
        check_val("ru_n1_outs", outs(), 32'h28);    // busy + mem_rd_valid
        step();                                     // N+2 MRD_WAIT
        check_val("ru_n2_outs", outs(), 32'h20);
        step();                                     // N+3
        mem_rd_done = 1;
        step();                                     // N+4 RSP_SEND
        mem_rd_done = 0;
        check_val("ru_n4_outs", outs(), 32'h21);    // compdata
        step();                                     // N+5 ACK_WAIT
        check_val("ru_n5_outs", outs(), 32'h20);
        step();                                     // N+6
        rxrsp_compack_valid = 1;
        step();                                     // N+7
        rxrsp_compack_valid = 0;
        check_val("ru_n7_outs", outs(), 32'h40);
        check_val("ru_n7_cnt", done_cnt, 1);
        check_val("ru_n7_err", proto_err, 0);

        // ReadUnique with snoop returning data: write-back after compack
        request(2'd0, 1'b1);
        check_val("rus_snd_outs", outs(), 32'h30);  // busy + txsnp_valid
        step();                                     // SNP_WAIT
        check_val("rus_wait_outs", outs(), 32'h20);
        rxdat_snprespdata_valid = 1;
        step();
        rxdat_snprespdata_valid = 0;
        check_val("rus_rsp_outs", outs(), 32'h21);  // compdata, no mem_rd
        step();
        rxrsp_compack_valid = 1;
        step();
        rxrsp_compack_valid = 0;
        check_val("rus_mwr_outs", outs(), 32'h24);  // mem_wr_valid
        step();
        check_val("rus_end_outs", outs(), 32'h40);
        check_val("rus_cnt", done_cnt, 2);

        // WriteBackFull, snp_needed ignored, txrsp_ready low for 5 cycles
        txrsp_ready = 0;
        request(2'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_val("wb_hold_outs", outs(), 32'h22);
            step();
        end
        txrsp_ready = 1;
        check_val("wb_rel_outs", outs(), 32'h22);
        step();                                     // ACK_WAIT
        check_val("wb_ack_outs", outs(), 32'h20);
        rxdat_cbwrdata_valid = 1;
        step();
        rxdat_cbwrdata_valid = 0;
        check_val("wb_mwr_outs", outs(), 32'h24);
        step();
        check_val("wb_end_outs", outs(), 32'h40);
        check_val("wb_cnt", done_cnt, 3);
        check_val("wb_err", proto_err, 0);

        // MakeUnique, both snoop responses together
        request(2'd1, 1'b1);
        check_val("mu_snd_outs", outs(), 32'h30);
        step();
        rxrsp_snpresp_valid = 1; rxdat_snprespdata_valid = 1;
        step();
        rxrsp_snpresp_valid = 0; rxdat_snprespdata_valid = 0;
        check_val("mu_rsp_comp", txrsp_comp_valid, 1);
        check_val("mu_rsp_outs", outs(), 32'h22);
        step();
        rxrsp_compack_valid = 1;
        step();
        rxrsp_compack_valid = 0;
        check_val("mu_end_outs", outs(), 32'h40);   // no mem_wr
        check_val("mu_cnt", done_cnt, 4);
        check_val("mu_err", proto_err, 0);

        // Stray compack in IDLE, then reserved opcode
        rxrsp_compack_valid = 1;
        step();
        rxrsp_compack_valid = 0;
        check_val("stray_err", proto_err, 1);
        check_val("stray_outs", outs(), 32'h40);
        request(2'd3, 1'b0);
        check_val("op3_outs", outs(), 32'h40);
        step();
        step();
        check_val("op3_err_sticky", proto_err, 1);
        check_val("op3_cnt", done_cnt, 4);

        // Reset mid-transaction in MRD_WAIT
        request(2'd0, 1'b0);
        step();
        check_val("mrdw_outs", outs(), 32'h20);
        #2 reset_n = 1'b0;
        #1;
        check_val("arst_outs", outs(), 32'h40);
        check_val("arst_err", proto_err, 0);
        check_val("arst_cnt", done_cnt, 0);
        step();
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("post_rst_outs", outs(), 32'h40);
        end

        // 256 MakeUnique transactions without snoop: counter wraps to 0
        for (int t = 0; t < 256; t++) begin
            request(2'd1, 1'b0);
            step();
            rxrsp_compack_valid = 1;
            step();
            rxrsp_compack_valid = 0;
            if (t == 254) check_val("wrap_255", done_cnt, 255);
        end
        check_val("wrap_0", done_cnt, 0);
        check_val("wrap_err", proto_err, 0);

        // Wrong completion type in ACK_WAIT is flagged and does not advance
        request(2'd1, 1'b0);
        step();
        rxdat_cbwrdata_valid = 1;
        step();
        rxdat_cbwrdata_valid = 0;
        check_val("wrong_ack_err", proto_err, 1);
        check_val("wrong_ack_outs", outs(), 32'h20);
        rxrsp_compack_valid = 1;
        step();
        rxrsp_compack_valid = 0;
        check_val("wrong_ack_end", outs(), 32'h40);
        check_val("wrong_ack_cnt", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
